mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, max cycles waiting for mem_resp before abort (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 Port: clk  input  1  rising-edge clock; sole clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: f_req  input  1  fetch requester read request; held until f_done.
REQ-005 Port: f_addr  input  14  fetch byte address.
REQ-006 Port: f_done  output  1  one-cycle fetch completion pulse.
REQ-007 Port: f_rdata  output  8  fetch read data; valid with f_done.
REQ-008 Port: d_req  input  1  data requester request; held until d_done.
REQ-009 Port: d_we  input  1  data requester: 1 = store, 0 = load.
REQ-010 Port: d_addr  input  14  data byte address.
REQ-011 Port: d_wdata  input  16  store data.
REQ-012 Port: d_done  output  1  one-cycle data completion pulse.
REQ-013 Port: d_rdata  output  8  load data; valid with d_done.
REQ-014 Port: read_req / write_req  output  1 each  request strobes to system memory; never both high.
REQ-015 Port: addrout  output  14  memory address.
REQ-016 Port: datatomem  output  16  memory write data.
REQ-017 Port: datafrommem  input  8  memory read data, sampled when mem_resp=1.
REQ-018 Port: mem_resp  input  1  memory response.
REQ-019 Port: busy  output  1  high in any state other than IDLE.
REQ-020 Port: err  output  1  timeout flag; pulses with the aborted port's done (tied 0 without macro).

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, DONE; encoding in package.
REQ-022 IDLE: if any req is high, latch winner id, addr, we and wdata into internal registers, then go to ISSUE the next cycle; otherwise stay in IDLE.
REQ-023 Arbitration: round-robin. With both requests high, grant the port not granted last; the last-grant flop resets to fetch, so data wins the first tie.
REQ-024 ISSUE: drive addrout and datatomem from latched values; assert read_req (load or fetch) or write_req (store); go to WAIT.
REQ-025 WAIT: hold the strobe, addrout and datatomem stable until mem_resp=1. In that cycle, drop the strobe, capture datafrommem for reads, and go to DONE.
REQ-026 DONE: pulse the granted port's done for exactly one cycle with rdata valid (rdata holds its value afterwards); go to IDLE.
REQ-027 Minimum latency: req high in cycle N with mem_resp at N+2 gives done at N+3.
REQ-028 Requests arriving while busy are not sampled until IDLE; de-asserting req mid-transaction does not abort it.
REQ-029 mem_resp in IDLE, ISSUE or DONE is ignored.
REQ-030 Stores return no data: d_rdata is unchanged on store completion.

Reset
REQ-031 Reset in any state returns the FSM to IDLE next edge and overrides all else, including a mid-transaction abort with no done pulse.
REQ-032 Reset values: all outputs 0, last-grant = fetch, timeout counter 0.

Configuration
REQ-033 Macro MEM_ARB_TIMEOUT_EN.
- Defined: a counter clears on entering WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without mem_resp, drop the strobe, go to DONE, pulse done with err=1 and rdata unchanged.
- Undefined: WAIT never exits without mem_resp; err is tied 0; no counter logic.

Structure
REQ-034 Package mem_arb_pkg holds the state enum, the port-id enum (PORT_F, PORT_D), and address/data width constants (14, 16, 8).
REQ-035 One sub-module, mem_arb_rr, holds the two-input round-robin pick and the last-grant flop; the FSM stays in mem_arbiter.

Verification
REQ-036 Scenario: f_req with f_addr=0x0123 and mem_resp 2 cycles after read_req, datafrommem=0xA5 -> addrout=0x0123, one f_done pulse, f_rdata=0xA5, write_req never high.
REQ-037 Scenario: d_req, d_we=1, d_addr=0x3FFF, d_wdata=0xBEEF -> write_req high until mem_resp, datatomem=0xBEEF, d_done pulses, d_rdata unchanged.
REQ-038 Scenario: f_req and d_req both high out of reset, held continuously -> grant order D, F, D, F across four completions.
REQ-039 Scenario: reset asserted in WAIT -> next cycle read_req=0, busy=0, no done pulse; a fresh request then completes normally.
REQ-040 Scenario: with MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_resp never asserted -> strobe drops after 4 WAIT cycles, done and err pulse together; without the macro busy stays high.
REQ-041 Scenario: mem_resp pulsed in IDLE -> no state change, no done.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and widths for the two-port memory arbiter.
//   state_e   : arbiter FSM states (IDLE, ISSUE, WAIT, DONE)
//   port_id_e : requester identity (PORT_F = fetch, PORT_D = data)
//   ADDR_W / WDATA_W / RDATA_W : address, write-data and read-data widths
package mem_arb_pkg;

    localparam int ADDR_W  = 14;
    localparam int WDATA_W = 16;
    localparam int RDATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_D = 1'b1
    } port_id_e;

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr -- two-input round-robin pick with its last-grant flop.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   f_req      : fetch port is requesting
//   d_req      : data port is requesting
//   grant_en   : a grant is being taken this cycle (arbiter is idle)
//   grant_d    : 1 = data port wins, 0 = fetch port wins (valid when a req is high)
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic f_req,
    input  logic d_req,
    input  logic grant_en,
    output logic grant_d
);

    port_id_e last_q, last_d;
    port_id_e pick;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        if (f_req && d_req) begin
            // Tie: favour the port that did not win last time.
            pick = (last_q == PORT_F) ? PORT_D : PORT_F;
        end else if (d_req) begin
            pick = PORT_D;
        end else begin
            pick = PORT_F;
        end

        last_d = last_q;
        if (grant_en && (f_req || d_req)) begin
            last_d = pick;
        end

        grant_d = (pick == PORT_D);
    end

    // NOTE: flops use non-blocking assignments so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PORT_F;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates a fetch port and a data port onto one memory port.
// One transaction at a time: IDLE latches the winner, ISSUE/WAIT drive the
// strobe until mem_resp, DONE pulses the winner's done for one cycle.
// Optional feature macro: MEM_ARB_TIMEOUT_EN -- aborts a WAIT that lasts
// TIMEOUT_CYCLES cycles, completing with err=1 and read data untouched.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   f_req, f_addr                 : fetch read request and byte address
//   f_done, f_rdata               : fetch completion pulse and read data
//   d_req, d_we, d_addr, d_wdata  : data request, store select, address, store data
//   d_done, d_rdata               : data completion pulse and load data
//   read_req, write_req           : memory strobes (mutually exclusive)
//   addrout, datatomem            : memory address and write data
//   datafrommem, mem_resp         : memory read data and response
//   busy                          : arbiter not idle
//   err                           : timeout flag, pulses with done
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               f_req,
    input  logic [ADDR_W-1:0]  f_addr,
    output logic               f_done,
    output logic [RDATA_W-1:0] f_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [WDATA_W-1:0] d_wdata,
    output logic               d_done,
    output logic [RDATA_W-1:0] d_rdata,
    output logic               read_req,
    output logic               write_req,
    output logic [ADDR_W-1:0]  addrout,
    output logic [WDATA_W-1:0] datatomem,
    input  logic [RDATA_W-1:0] datafrommem,
    input  logic               mem_resp,
    output logic               busy,
    output logic               err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_e               state_q, state_d;
    port_id_e             id_q, id_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [WDATA_W-1:0]   wdata_q, wdata_d;
    logic [RDATA_W-1:0]   f_rdata_q, f_rdata_d;
    logic [RDATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                 grant_en;
    logic                 grant_d;
    logic                 timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tout_q, tout_d;
`endif

    assign grant_en = (state_q == ST_IDLE);

    mem_arb_rr u_rr (
        .clk      (clk),
        .reset    (reset),
        .f_req    (f_req),
        .d_req    (d_req),
        .grant_en (grant_en),
        .grant_d  (grant_d)
    );

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        // Last permitted WAIT cycle with no response yet.
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
        case (state_q)
            ST_IDLE:  if (f_req || d_req) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (mem_resp || timeout_hit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Transaction latch and read-data capture.
    always_comb begin
        id_d      = id_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;

        if (state_q == ST_IDLE && (f_req || d_req)) begin
            if (grant_d) begin
                id_d    = PORT_D;
                we_d    = d_we;
                addr_d  = d_addr;
                wdata_d = d_wdata;
            end else begin
                id_d    = PORT_F;
                we_d    = 1'b0;
                addr_d  = f_addr;
                wdata_d = '0;
            end
        end

        // Stores return nothing, so only reads update the winner's rdata.
        if (state_q == ST_WAIT && mem_resp && !we_q) begin
            if (id_q == PORT_D) begin
                d_rdata_d = datafrommem;
            end else begin
                f_rdata_d = datafrommem;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_comb begin
        cnt_d  = cnt_q;
        tout_d = 1'b0;
        if (state_q == ST_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            cnt_d  = cnt_q + CNT_W'(1);
            tout_d = !mem_resp && timeout_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            id_q      <= PORT_F;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        read_req  = 1'b0;
        write_req = 1'b0;
        if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
            read_req  = !we_q;
            write_req = we_q;
        end
        f_done    = (state_q == ST_DONE) && (id_q == PORT_F);
        d_done    = (state_q == ST_DONE) && (id_q == PORT_D);
        addrout   = addr_q;
        datatomem = wdata_q;
        f_rdata   = f_rdata_q;
        d_rdata   = d_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        err       = tout_q;
`else
        err       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- self-checking bench for mem_arbiter: a directed vector
// table, hand-written reset/idle/timeout sequences, and randomized
// transactions predicted by a transaction-level round-robin model.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, d_req, d_we, mem_resp;
    logic [13:0] f_addr, d_addr;
    logic [15:0] d_wdata;
    logic [7:0]  datafrommem;
    logic        f_done, d_done, read_req, write_req, busy, err;
    logic [7:0]  f_rdata, d_rdata;
    logic [13:0] addrout;
    logic [15:0] datatomem;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_done      (f_done),
        .f_rdata     (f_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_done      (d_done),
        .d_rdata     (d_rdata),
        .read_req    (read_req),
        .write_req   (write_req),
        .addrout     (addrout),
        .datatomem   (datatomem),
        .datafrommem (datafrommem),
        .mem_resp    (mem_resp),
        .busy        (busy),
        .err         (err)
    );

    typedef struct {
        bit          rst_before;
        bit          f;
        bit          d;
        logic [13:0] fa;
        bit          we;
        logic [13:0] da;
        logic [15:0] wd;
        int          lat;
        logic [7:0]  md;
        bit          exp_d;
        bit          exp_wr;
        logic [13:0] exp_addr;
        logic [15:0] exp_wd;
        logic [7:0]  exp_frd;
        logic [7:0]  exp_drd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_resp = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; datafrommem = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    // One complete transaction from IDLE back to IDLE, cycle-exact:
    // req sampled -> ISSUE -> WAIT (1+lat cycles) -> DONE -> IDLE.
    task automatic run_txn(input string tag, input bit f, input bit d,
                           input logic [13:0] fa, input bit we, input logic [13:0] da,
                           input logic [15:0] wd, input int lat, input logic [7:0] md,
                           input bit noise, input bit exp_d, input bit exp_wr,
                           input logic [13:0] exp_addr, input logic [15:0] exp_wd,
                           input logic [7:0] exp_frd, input logic [7:0] exp_drd);
        bit held_ok;
        f_req = f; d_req = d; f_addr = fa; d_we = we; d_addr = da; d_wdata = wd;
        step();
        check({tag, " issue strobes"}, 32'({read_req, write_req}), 32'({!exp_wr, exp_wr}));
        check({tag, " issue addr"}, 32'(addrout), 32'(exp_addr));
        check({tag, " issue busy"}, 32'(busy), 32'd1);
        if (exp_wr) check({tag, " wdata"}, 32'(datatomem), 32'(exp_wd));
        // mem_resp during ISSUE must be ignored.
        if (noise) mem_resp = 1'($urandom_range(0, 1));
        step();
        mem_resp = 1'b0;
        if (noise) begin
            f_req = 1'($urandom_range(0, 1));
            d_req = 1'($urandom_range(0, 1));
        end
        held_ok = 1'b1;
        for (int i = 0; i <= lat; i++) begin
            if (read_req !== !exp_wr || write_req !== exp_wr || addrout !== exp_addr ||
                f_done !== 1'b0 || d_done !== 1'b0 || busy !== 1'b1)
                held_ok = 1'b0;
            if (exp_wr && datatomem !== exp_wd) held_ok = 1'b0;
            if (i < lat) step();
        end
        check({tag, " wait held"}, 32'(held_ok), 32'd1);
        mem_resp    = 1'b1;
        datafrommem = md;
        step();
        mem_resp    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        datafrommem = 8'($urandom);
        check({tag, " done pair"}, 32'({f_done, d_done}), 32'({!exp_d, exp_d}));
        check({tag, " done strobes off"}, 32'({read_req, write_req}), 32'd0);
        check({tag, " done err"}, 32'(err), 32'd0);
        check({tag, " f_rdata"}, 32'(f_rdata), 32'(exp_frd));
        check({tag, " d_rdata"}, 32'(d_rdata), 32'(exp_drd));
        step();
        mem_resp = 1'b0;
        check({tag, " idle done/busy"}, 32'({f_done, d_done, busy}), 32'd0);
        check({tag, " idle rdata hold"}, 32'({f_rdata, d_rdata}), 32'({exp_frd, exp_drd}));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        bit          m_last_d;
        logic [7:0]  m_frd, m_drd;
        bit          rf, rd, rwe, win_d, wr;
        logic [13:0] rfa, rda;
        logic [15:0] rwd;
        logic [7:0]  rmd;
        int          rlat;

        //            rst f  d  fa       we da       wd        lat md     ed wr addr     wd        frd    drd
        vecs[0] = '{1'b0,1'b1,1'b0,14'h0123,1'b0,14'h0000,16'h0000,1,8'hA5,1'b0,1'b0,14'h0123,16'h0000,8'hA5,8'h00};
        vecs[1] = '{1'b0,1'b0,1'b1,14'h0000,1'b1,14'h3FFF,16'hBEEF,2,8'h77,1'b1,1'b1,14'h3FFF,16'hBEEF,8'hA5,8'h00};
        vecs[2] = '{1'b1,1'b1,1'b1,14'h0010,1'b0,14'h0020,16'h0000,0,8'h11,1'b1,1'b0,14'h0020,16'h0000,8'h00,8'h11};
        vecs[3] = '{1'b0,1'b1,1'b1,14'h0010,1'b0,14'h0020,16'h0000,0,8'h22,1'b0,1'b0,14'h0010,16'h0000,8'h22,8'h11};
        vecs[4] = '{1'b0,1'b1,1'b1,14'h0010,1'b0,14'h0020,16'h0000,0,8'h33,1'b1,1'b0,14'h0020,16'h0000,8'h22,8'h33};
        vecs[5] = '{1'b0,1'b1,1'b1,14'h0010,1'b0,14'h0020,16'h0000,0,8'h44,1'b0,1'b0,14'h0010,16'h0000,8'h44,8'h33};
        vecs[6] = '{1'b0,1'b0,1'b1,14'h0000,1'b0,14'h1555,16'h0000,3,8'hC3,1'b1,1'b0,14'h1555,16'h0000,8'h44,8'hC3};
        vecs[7] = '{1'b0,1'b0,1'b1,14'h0000,1'b1,14'h0000,16'h1234,1,8'h0F,1'b1,1'b1,14'h0000,16'h1234,8'h44,8'hC3};
        vecs[8] = '{1'b0,1'b1,1'b0,14'h2AAA,1'b0,14'h0000,16'h0000,2,8'h5A,1'b0,1'b0,14'h2AAA,16'h0000,8'h5A,8'hC3};
        vecs[9] = '{1'b0,1'b1,1'b1,14'h0111,1'b1,14'h0F0F,16'hFFFF,0,8'hE1,1'b1,1'b1,14'h0F0F,16'hFFFF,8'h5A,8'hC3};

        // Reset state.
        do_reset();
        check("reset strobes", 32'({read_req, write_req}), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done/err", 32'({f_done, d_done, err}), 32'd0);
        check("reset addr/data", 32'({addrout, datatomem}), 32'd0);
        check("reset rdata", 32'({f_rdata, d_rdata}), 32'd0);

        // Directed vectors (fetch read, store, tie sequence D,F,D,F, mixed).
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst_before) do_reset();
            run_txn($sformatf("vec%0d", i), vecs[i].f, vecs[i].d, vecs[i].fa, vecs[i].we,
                    vecs[i].da, vecs[i].wd, vecs[i].lat, vecs[i].md, 1'b0, vecs[i].exp_d,
                    vecs[i].exp_wr, vecs[i].exp_addr, vecs[i].exp_wd, vecs[i].exp_frd,
                    vecs[i].exp_drd);
        end
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

        // mem_resp while idle changes nothing.
        mem_resp = 1'b1; datafrommem = 8'hFF;
        step();
        mem_resp = 1'b0;
        check("idle resp busy", 32'(busy), 32'd0);
        check("idle resp done/strobe", 32'({f_done, d_done, read_req, write_req}), 32'd0);
        check("idle resp rdata", 32'({f_rdata, d_rdata}), 32'({8'h5A, 8'hC3}));
        step();
        check("idle resp busy later", 32'({busy, f_done, d_done}), 32'd0);

        // Reset while waiting aborts silently; a fresh request then completes.
        f_req = 1'b1; f_addr = 14'h0456;
        step();
        step();
        check("pre-abort read_req", 32'(read_req), 32'd1);
        reset = 1'b1; f_req = 1'b0;
        step();
        reset = 1'b0;
        check("abort strobe/busy", 32'({read_req, write_req, busy}), 32'd0);
        check("abort no done", 32'({f_done, d_done}), 32'd0);
        step();
        check("abort still idle", 32'({busy, f_done, d_done}), 32'd0);
        run_txn("after abort", 1'b1, 1'b0, 14'h0456, 1'b0, 14'h0000, 16'h0000, 1, 8'h3C,
                1'b0, 1'b0, 1'b0, 14'h0456, 16'h0000, 8'h3C, 8'h00);
        f_req = 1'b0;

        // Memory that never responds.
        f_req = 1'b1; f_addr = 14'h0789;
        step();
        step();
        f_req = 1'b0;
        ok = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            if (read_req !== 1'b1 || busy !== 1'b1 || f_done !== 1'b0 || err !== 1'b0) ok = 1'b0;
            step();
        end
        check("timeout wait held", 32'(ok), 32'd1);
        check("timeout strobe off", 32'(read_req), 32'd0);
        check("timeout done/err", 32'({f_done, d_done, err}), 32'b101);
        check("timeout rdata kept", 32'(f_rdata), 32'h3C);
        step();
        check("timeout idle", 32'({busy, f_done, err}), 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            if (read_req !== 1'b1 || busy !== 1'b1 || f_done !== 1'b0 || err !== 1'b0) ok = 1'b0;
            step();
        end
        check("no-timeout busy held", 32'(ok), 32'd1);
        mem_resp = 1'b1; datafrommem = 8'h99;
        step();
        mem_resp = 1'b0;
        check("late resp done/err", 32'({f_done, d_done, err}), 32'b100);
        check("late resp rdata", 32'(f_rdata), 32'h99);
        step();
        check("late resp idle", 32'({busy, f_done}), 32'd0);
`endif

        // Randomized transactions against a transaction-level model.
        do_reset();
        m_last_d = 1'b0;
        m_frd    = 8'h00;
        m_drd    = 8'h00;
        for (int n = 0; n < 80; n++) begin
            rf   = 1'($urandom_range(0, 1));
            rd   = 1'($urandom_range(0, 1));
            if (!rf && !rd) rd = 1'b1;
            rwe  = 1'($urandom_range(0, 1));
            rfa  = 14'($urandom);
            rda  = 14'($urandom);
            rwd  = 16'($urandom);
            rmd  = 8'($urandom);
            rlat = $urandom_range(0, 3);
            win_d    = (rf && rd) ? !m_last_d : rd;
            m_last_d = win_d;
            wr       = win_d && rwe;
            if (!wr) begin
                if (win_d) m_drd = rmd;
                else       m_frd = rmd;
            end
            run_txn($sformatf("rand%0d", n), rf, rd, rfa, rwe, rda, rwd, rlat, rmd, 1'b1,
                    win_d, wr, win_d ? rda : rfa, rwd, m_frd, m_drd);
        end
        f_req = 1'b0; d_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
